// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StRinging = 2'd2,
    StSnooze  = 2'd3
  } alarm_state_e;

  localparam int unsigned SNOOZE_SEC = 300;
  localparam int unsigned RING_SEC   = 60;
  localparam int unsigned MAX_SNOOZE = 3;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds countdown; decrements on sec_tick while enabled, saturates at zero.
module sec_countdown #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sec_tick,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && sec_tick && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm clock sequencer: arms on enable, rings on time match, handles snooze/stop/auto-snooze.
module alarm_sequencer #(
  parameter int unsigned SNOOZE_SEC = alarm_pkg::SNOOZE_SEC,
  parameter int unsigned RING_SEC   = alarm_pkg::RING_SEC,
  parameter int unsigned MAX_SNOOZE = alarm_pkg::MAX_SNOOZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       bud_en,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  input  logic [3:0] hourdec_bud,
  input  logic [3:0] hourone_bud,
  input  logic [3:0] mindec_bud,
  input  logic [3:0] minone_bud,
  input  logic       snooze_req,
  input  logic       stop_req,
  output logic       aud_en,
  output logic       bud_state,
  output logic [1:0] state_o,
  output logic [2:0] snooze_left
);

  import alarm_pkg::*;

  localparam int unsigned TMAX = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
  localparam int unsigned CW   = cnt_width(TMAX);
  localparam int unsigned SW   = cnt_width(MAX_SNOOZE);

  localparam logic [CW-1:0] RING_LOAD   = CW'(RING_SEC);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SEC);

  alarm_state_e  state_q, state_d;
  logic          aud_en_q, aud_en_d;
  logic [SW-1:0] snz_q, snz_d;
  logic          match_seen_q, match_seen_d;

  logic          match, trigger, expire;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic [CW-1:0] cnt;
  logic          cnt_zero;

  assign match = (hourdec_now == hourdec_bud) && (hourone_now == hourone_bud) &&
                 (mindec_now == mindec_bud) && (minone_now == minone_bud);

  assign trigger = bud_en && (state_q == StArmed) && match && !match_seen_q;

  // A zero-length load (parameter of 0) expires on the first tick.
  assign expire = sec_tick && ((cnt == CW'(1)) || cnt_zero);

  sec_countdown #(
    .WIDTH(CW)
  ) u_sec_countdown (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .sec_tick(sec_tick),
    .en      (bud_state),
    .count   (cnt),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    aud_en_d     = aud_en_q;
    snz_d        = snz_q;
    cnt_load     = 1'b0;
    cnt_load_val = RING_LOAD;
    match_seen_d = match ? (match_seen_q | trigger) : 1'b0;

    if (!bud_en) begin
      state_d  = StIdle;
      aud_en_d = 1'b0;
      snz_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArmed;
        StArmed: begin
          if (trigger) begin
            state_d  = StRinging;
            aud_en_d = 1'b1;
            snz_d    = SW'(MAX_SNOOZE);
            cnt_load = 1'b1;
          end
        end
        StRinging: begin
          if (stop_req) begin
            state_d  = StArmed;
            aud_en_d = 1'b0;
          end else if ((snooze_req || expire) && (snz_q != '0)) begin
            state_d      = StSnooze;
            aud_en_d     = 1'b0;
            snz_d        = snz_q - SW'(1);
            cnt_load     = 1'b1;
            cnt_load_val = SNOOZE_LOAD;
          end else if (expire) begin
            state_d  = StArmed;
            aud_en_d = 1'b0;
          end else if (sec_tick) begin
            aud_en_d = ~aud_en_q;
          end
        end
        StSnooze: begin
          if (stop_req) begin
            state_d  = StArmed;
            aud_en_d = 1'b0;
          end else if (expire) begin
            state_d  = StRinging;
            aud_en_d = 1'b1;
            cnt_load = 1'b1;
          end
        end
        default: begin
          state_d  = StIdle;
          aud_en_d = 1'b0;
        end
      endcase
    end
  end

  // match_seen resets high so a match already present at reset does not ring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      aud_en_q     <= 1'b0;
      snz_q        <= '0;
      match_seen_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      aud_en_q     <= aud_en_d;
      snz_q        <= snz_d;
      match_seen_q <= match_seen_d;
    end
  end

  assign aud_en      = aud_en_q;
  assign bud_state   = (state_q == StRinging) || (state_q == StSnooze);
  assign state_o     = state_q;
  assign snooze_left = 3'(snz_q);

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with SNOOZE_SEC=5, RING_SEC=4, MAX_SNOOZE=2.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sec_tick;
  logic       bud_en;
  logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
  logic [3:0] hourdec_bud, hourone_bud, mindec_bud, minone_bud;
  logic       snooze_req, stop_req;
  logic       aud_en, bud_state;
  logic [1:0] state_o;
  logic [2:0] snooze_left;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alarm_sequencer #(
    .SNOOZE_SEC(5),
    .RING_SEC  (4),
    .MAX_SNOOZE(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sec_tick   (sec_tick),
    .bud_en     (bud_en),
    .hourdec_now(hourdec_now),
    .hourone_now(hourone_now),
    .mindec_now (mindec_now),
    .minone_now (minone_now),
    .hourdec_bud(hourdec_bud),
    .hourone_bud(hourone_bud),
    .mindec_bud (mindec_bud),
    .minone_bud (minone_bud),
    .snooze_req (snooze_req),
    .stop_req   (stop_req),
    .aud_en     (aud_en),
    .bud_state  (bud_state),
    .state_o    (state_o),
    .snooze_left(snooze_left)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_time(input logic [3:0] hd, input logic [3:0] ho,
                          input logic [3:0] md, input logic [3:0] mo);
    hourdec_now = hd;
    hourone_now = ho;
    mindec_now  = md;
    minone_now  = mo;
  endtask

  task automatic test_reset();
    cycles(2);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if (aud_en !== 1'b0) begin errors++; $display("FAIL reset_aud got=%b exp=0", aud_en); end
    checks++; if (bud_state !== 1'b0) begin errors++; $display("FAIL reset_bud got=%b exp=0", bud_state); end
    checks++; if (snooze_left !== 3'd0) begin errors++; $display("FAIL reset_left got=%0d exp=0", snooze_left); end
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_trigger();
    bud_en = 1'b1;
    cycles(1);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL arm_state got=%0d exp=1", state_o); end
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    cycles(1);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL trig_state got=%0d exp=2", state_o); end
    checks++; if (aud_en !== 1'b1) begin errors++; $display("FAIL trig_aud got=%b exp=1", aud_en); end
    checks++; if (snooze_left !== 3'd2) begin errors++; $display("FAIL trig_left got=%0d exp=2", snooze_left); end
    checks++; if (bud_state !== 1'b1) begin errors++; $display("FAIL trig_bud got=%b exp=1", bud_state); end
    tick();
    checks++; if (aud_en !== 1'b0) begin errors++; $display("FAIL toggle1_aud got=%b exp=0", aud_en); end
    tick();
    checks++; if (aud_en !== 1'b1) begin errors++; $display("FAIL toggle2_aud got=%b exp=1", aud_en); end
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL toggle_state got=%0d exp=2", state_o); end
  endtask

  task automatic test_snooze();
    snooze_req = 1'b1;
    cycles(1);
    snooze_req = 1'b0;
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL snz_state got=%0d exp=3", state_o); end
    checks++; if (snooze_left !== 3'd1) begin errors++; $display("FAIL snz_left got=%0d exp=1", snooze_left); end
    checks++; if (aud_en !== 1'b0) begin errors++; $display("FAIL snz_aud got=%b exp=0", aud_en); end
    ticks(4);
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL snz4_state got=%0d exp=3", state_o); end
    tick();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL wake_state got=%0d exp=2", state_o); end
    checks++; if (aud_en !== 1'b1) begin errors++; $display("FAIL wake_aud got=%b exp=1", aud_en); end
    checks++; if (snooze_left !== 3'd1) begin errors++; $display("FAIL wake_left got=%0d exp=1", snooze_left); end
  endtask

  task automatic test_stop_priority();
    stop_req   = 1'b1;
    snooze_req = 1'b1;
    cycles(1);
    stop_req   = 1'b0;
    snooze_req = 1'b0;
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL stop_state got=%0d exp=1", state_o); end
    checks++; if (aud_en !== 1'b0) begin errors++; $display("FAIL stop_aud got=%b exp=0", aud_en); end
    cycles(4);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL noretrig_state got=%0d exp=1", state_o); end
    set_time(4'd0, 4'd7, 4'd3, 4'd1);
    cycles(2);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL min31_state got=%0d exp=1", state_o); end
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    cycles(1);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL nextday_state got=%0d exp=2", state_o); end
    checks++; if (snooze_left !== 3'd2) begin errors++; $display("FAIL nextday_left got=%0d exp=2", snooze_left); end
  endtask

  task automatic test_timeout();
    ticks(3);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL ring3_state got=%0d exp=2", state_o); end
    checks++; if (aud_en !== 1'b0) begin errors++; $display("FAIL ring3_aud got=%b exp=0", aud_en); end
    tick();
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL auto1_state got=%0d exp=3", state_o); end
    checks++; if (snooze_left !== 3'd1) begin errors++; $display("FAIL auto1_left got=%0d exp=1", snooze_left); end
    ticks(5);
    ticks(4);
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL auto2_state got=%0d exp=3", state_o); end
    checks++; if (snooze_left !== 3'd0) begin errors++; $display("FAIL auto2_left got=%0d exp=0", snooze_left); end
    ticks(5);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL wake2_state got=%0d exp=2", state_o); end
    snooze_req = 1'b1;
    cycles(1);
    snooze_req = 1'b0;
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL snz0_state got=%0d exp=2", state_o); end
    checks++; if (aud_en !== 1'b1) begin errors++; $display("FAIL snz0_aud got=%b exp=1", aud_en); end
    ticks(4);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL final_state got=%0d exp=1", state_o); end
    checks++; if (aud_en !== 1'b0) begin errors++; $display("FAIL final_aud got=%b exp=0", aud_en); end
    checks++; if (snooze_left !== 3'd0) begin errors++; $display("FAIL final_left got=%0d exp=0", snooze_left); end
  endtask

  task automatic test_bud_disable();
    set_time(4'd0, 4'd7, 4'd3, 4'd1);
    cycles(1);
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    cycles(1);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL dis_ring_state got=%0d exp=2", state_o); end
    bud_en = 1'b0;
    cycles(1);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL dis_state got=%0d exp=0", state_o); end
    checks++; if (aud_en !== 1'b0) begin errors++; $display("FAIL dis_aud got=%b exp=0", aud_en); end
    checks++; if (bud_state !== 1'b0) begin errors++; $display("FAIL dis_bud got=%b exp=0", bud_state); end
    bud_en = 1'b1;
    cycles(3);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL reen_state got=%0d exp=1", state_o); end
  endtask

  task automatic test_reset_mid_snooze();
    set_time(4'd0, 4'd7, 4'd3, 4'd1);
    cycles(1);
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    cycles(1);
    snooze_req = 1'b1;
    cycles(1);
    snooze_req = 1'b0;
    tick();
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL pre_rst_state got=%0d exp=3", state_o); end
    rst = 1'b1;
    #1;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL arst_state got=%0d exp=0", state_o); end
    checks++; if (aud_en !== 1'b0) begin errors++; $display("FAIL arst_aud got=%b exp=0", aud_en); end
    checks++; if (bud_state !== 1'b0) begin errors++; $display("FAIL arst_bud got=%b exp=0", bud_state); end
    checks++; if (snooze_left !== 3'd0) begin errors++; $display("FAIL arst_left got=%0d exp=0", snooze_left); end
    @(negedge clk);
    rst = 1'b0;
    cycles(3);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL post_rst_state got=%0d exp=1", state_o); end
  endtask

  initial begin
    rst        = 1'b1;
    sec_tick   = 1'b0;
    bud_en     = 1'b0;
    snooze_req = 1'b0;
    stop_req   = 1'b0;
    set_time(4'd0, 4'd7, 4'd2, 4'd9);
    hourdec_bud = 4'd0;
    hourone_bud = 4'd7;
    mindec_bud  = 4'd3;
    minone_bud  = 4'd0;

    test_reset();
    test_trigger();
    test_snooze();
    test_stop_priority();
    test_timeout();
    test_bud_disable();
    test_reset_mid_snooze();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
